// File: rtl/tx_send_queue.sv
// Button-driven byte feeder for the UART transmitter: debounces btnL, queues the
// sw byte on each press and issues queued bytes over a ready/start handshake.
module tx_send_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned WIDTH           = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         sw,
  input  logic                     btnL,
  input  logic                     tx_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACK, BUSY} state_t;

  logic             sync1, sync2, deb;
  logic [DW-1:0]    deb_cnt;
  logic             press_c, push_c, pop_c, drop_c, start_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count_d;
  logic [1:0]       ack_tmr;
  state_t           state, state_d;

  // Press fires on the same edge the debounced level rises, saving a cycle of latency.
  assign press_c = sync2 & ~deb & (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign push_c  = press_c & (~full | pop_c);
  assign drop_c  = press_c & full & ~pop_c;
  assign count_d = count + CW'(push_c) - CW'(pop_c);

  // Two-flop synchroniser and debounce counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btnL;
      sync2 <= sync1;
      if (sync2 != deb) begin
        if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb     <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) mem[wptr] <= sw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_c) wptr <= wptr + AW'(1);
      if (pop_c)  rptr <= rptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
      if (drop_c) overflow <= 1'b1;
    end
  end

  // Issue FSM state register plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      ack_tmr  <= '0;
    end else begin
      state    <= state_d;
      tx_start <= start_d;
      if (pop_c) tx_data <= mem[rptr];
      ack_tmr  <= (state == ACK) ? ack_tmr + 2'd1 : 2'd0;
    end
  end

  // ACK gives up after four cycles of tx_ready staying high, so a missed start cannot deadlock.
  always_comb begin
    state_d = state;
    pop_c   = 1'b0;
    start_d = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop_c   = 1'b1;
          start_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!tx_ready)              state_d = BUSY;
        else if (ack_tmr == 2'd3)   state_d = IDLE;
      end
      BUSY: begin
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_send_queue.sv
// Directed bench for tx_send_queue with a small transmitter model that drops
// ready one cycle after each start and keeps it low for 20 cycles.
module tb_tx_send_queue;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic             btnL;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic [2:0]       count;
  logic             full, empty, overflow;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int cyc = 0;
  bit hold_low = 1'b0;
  bit no_drop = 1'b0;
  logic [WIDTH-1:0] sent[$];
  int start_cyc[$];

  typedef struct {
    logic [WIDTH-1:0] sw;
    int               exp_count;
    bit               exp_full;
    bit               exp_empty;
    bit               exp_ovf;
  } vec_t;
  vec_t vt[5];

  tx_send_queue #(.DEBOUNCE_CYCLES(DEB), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btnL(btnL), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign tx_ready = (busy_cnt == 0) && !hold_low;

  // Transmitter model: not affected by rst.
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt--;
    else if (tx_start === 1'b1 && !no_drop) busy_cnt = 20;
  end

  // Record every start pulse and the edge it followed.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (tx_start === 1'b1) begin
      sent.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [WIDTH-1:0] v);
    @(negedge clk);
    sw   = v;
    btnL = 1'b1;
    repeat (10) @(negedge clk);
    btnL = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int k;
    bit found;

    vt[0] = '{8'h11, 1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h22, 2, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'h33, 3, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h44, 4, 1'b1, 1'b0, 1'b0};
    vt[4] = '{8'h55, 4, 1'b1, 1'b0, 1'b1};

    // Reset with garbage on the inputs.
    rst  = 1'b1;
    btnL = 1'b1;
    sw   = 8'hC3;
    repeat (3) @(negedge clk);
    btnL = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Single press: start after 6+-1 edges of btnL rising.
    sent.delete();
    @(negedge clk);
    sw   = 8'hA5;
    btnL = 1'b1;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (tx_start === 1'b1) found = 1'b1;
    end
    chk("single_start_seen", int'(found), 1);
    chk("single_latency_ok", int'(k >= 5 && k <= 7), 1);
    chk("single_data", int'(tx_data), 8'hA5);
    repeat (4) @(negedge clk);
    btnL = 1'b0;
    repeat (40) @(negedge clk);
    chk("single_starts", sent.size(), 1);
    chk("single_count", int'(count), 0);

    // Bounce rejection.
    sent.delete();
    sw = 8'h3E;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btnL = (i % 2 == 0);
      @(negedge clk);
    end
    btnL = 1'b1;
    repeat (10) @(negedge clk);
    btnL = 1'b0;
    repeat (40) @(negedge clk);
    chk("bounce_starts", sent.size(), 1);
    if (sent.size() == 1) chk("bounce_data", int'(sent[0]), 8'h3E);
    chk("bounce_empty", int'(empty), 1);

    // Queueing and overflow from a table, transmitter held not ready.
    sent.delete();
    hold_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      press(vt[i].sw);
      chk($sformatf("q%0d_count", i), int'(count), vt[i].exp_count);
      chk($sformatf("q%0d_full", i), int'(full), int'(vt[i].exp_full));
      chk($sformatf("q%0d_empty", i), int'(empty), int'(vt[i].exp_empty));
      chk($sformatf("q%0d_overflow", i), int'(overflow), int'(vt[i].exp_ovf));
    end
    chk("q_no_start_while_blocked", sent.size(), 0);
    hold_low = 1'b0;
    repeat (150) @(negedge clk);
    chk("q_starts", sent.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < sent.size()) chk($sformatf("q_order%0d", i), int'(sent[i]), int'(vt[i].sw));
    chk("q_overflow_sticky", int'(overflow), 1);
    chk("q_drained_empty", int'(empty), 1);

    // ACK timeout: transmitter never drops ready, starts spaced 5 cycles.
    sent.delete();
    start_cyc.delete();
    no_drop  = 1'b1;
    hold_low = 1'b1;
    press(8'h3C);
    press(8'h5A);
    hold_low = 1'b0;
    repeat (30) @(negedge clk);
    chk("to_starts", sent.size(), 2);
    if (sent.size() == 2) begin
      chk("to_data0", int'(sent[0]), 8'h3C);
      chk("to_data1", int'(sent[1]), 8'h5A);
      chk("to_spacing", start_cyc[1] - start_cyc[0], 5);
    end
    no_drop = 1'b0;

    // Reset mid-queue with one frame in BUSY.
    sent.delete();
    hold_low = 1'b1;
    press(8'h61);
    press(8'h62);
    press(8'h63);
    press(8'h64);
    hold_low = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 10) begin
      @(negedge clk);
      k++;
      if (tx_start === 1'b1) found = 1'b1;
    end
    chk("mid_first_start", int'(found), 1);
    repeat (3) @(negedge clk);
    chk("mid_count_before", int'(count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_empty", int'(empty), 1);
    chk("mid_count", int'(count), 0);
    chk("mid_overflow", int'(overflow), 0);
    chk("mid_tx_start", int'(tx_start), 0);
    repeat (60) @(negedge clk);
    chk("mid_no_more_starts", sent.size(), 1);
    press(8'h77);
    repeat (60) @(negedge clk);
    chk("mid_new_starts", sent.size(), 2);
    if (sent.size() == 2) chk("mid_new_data", int'(sent[1]), 8'h77);
    chk("mid_final_empty", int'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_send_queue.md
Name: tx_send_queue

Overview:
- Upstream feeder for the UART transmitter on the Basys3 loopback path.
- Synchronises and debounces btnL, and captures the sw byte on each debounced press into a small FIFO.
- Issues FIFO bytes one at a time to the transmitter using a ready/start handshake.
- Several rapid presses therefore queue up and are not lost while a frame is in flight.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a btnL level change (10 ms at 100 MHz).
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- WIDTH, 8, data byte width.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-high reset.
- sw  input  WIDTH  switch byte, sampled on the accepted press.
- btnL  input  1  raw, asynchronous, bouncy send button.
- tx_ready  input  1  high while the transmitter is idle and able to accept a frame.
- tx_data  output  WIDTH  byte presented to the transmitter.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a press was dropped while the FIFO was full.

Behaviour:
- Reset: one clock with rst high clears the following:
  - synchroniser flops, debounced level, debounce counter, FIFO pointers and count.
  - tx_data=0, tx_start=0, overflow=0, FSM=IDLE.
  - empty=1, full=0.
- Reset mid-operation:
  - Queued bytes are discarded.
  - A pending tx_start is cancelled.
  - The transmitter is not otherwise affected.
- Synchroniser: two flops on btnL.
- Debouncer:
  - When the synchronised value differs from the debounced level, the counter increments.
  - When they are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- Press event: a one-cycle pulse on the 0->1 transition of the debounced level. A release produces no event.
- Press latency: event fires DEBOUNCE_CYCLES+2 cycles after btnL rises cleanly (±1 for the first-cycle edge).
- Push:
  - On a press event, sw is written at the write pointer in that same cycle, and the pointer and count increment.
  - Pointers wrap modulo DEPTH.
- Full FIFO:
  - A press with full=1 and no pop that cycle is dropped; overflow sets and stays set until rst.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
- Push on empty: allowed.
  - A pop cannot coincide, because the FSM only pops when empty=0 at the start of the cycle.
  - The new byte is issued no earlier than the next cycle.
- Issue FSM:
  - IDLE: if empty=0 and tx_ready=1, do all of the following:
    - Register tx_data <= head entry.
    - Pulse tx_start for exactly one cycle, coincident with tx_data becoming valid.
    - Pop: read pointer +1, count -1.
    - Go to ACK.
  - ACK: wait for tx_ready=0 and go to BUSY.
    - A 4-cycle timeout applies: if tx_ready stays 1 for 4 cycles after the start pulse, go to IDLE. This treats the frame as done and avoids deadlock.
  - BUSY: wait for tx_ready=1, then go to IDLE.
  - tx_start is never asserted outside the IDLE->ACK transition.
  - Consecutive starts are at least 2 cycles apart.
- tx_data stability: held constant from the start pulse until the next start pulse.
- count/full/empty: registered; they reflect pushes and pops of the previous edge.
- Simultaneous press and pop on a non-full FIFO: count unchanged, both pointers advance.

Test Plan (bench uses DEBOUNCE_CYCLES=4, DEPTH=4; tx model drops ready 1 cycle after start and holds it low 20 cycles):
- Reset: drive garbage, assert rst for 1 cycle -> tx_start=0, tx_data=0x00, empty=1, count=0, overflow=0.
- Single press: sw=0xA5, btnL high 10 cycles -> exactly one tx_start pulse with tx_data=0xA5, 6±1 cycles after btnL rises; count returns to 0.
- Bounce rejection: btnL toggles every 2 cycles for 20 cycles, then settles high -> exactly one push, one start.
- Queueing and order: with tx_ready held 0, press with sw=0x11, 0x22, 0x33, 0x44 -> count=4, full=1; release tx_ready -> starts carry 0x11, 0x22, 0x33, 0x44 in order, each after the previous BUSY completes.
- Overflow: FIFO full, tx_ready=0, press with sw=0x55 -> count stays 4, overflow=1 and persists; 0x55 is never transmitted.
- Reset mid-queue: 3 bytes queued, one in BUSY, pulse rst -> empty=1, no further tx_start; the next press sends only the new byte.
